led_blink_coder: RTL and testbench
==================================

// Module: led_blink_coder
// PURPOSE
// Downstream consumer of the heartbeat toggle. Uses each heartbeat edge as a slow
// time-base tick to drive the board LED. With no error pending, the LED mirrors the
// heartbeat. With a nonzero error code, the LED blinks that many pulses, then pauses
// for a gap. An 8-bit PWM applies global brightness. Sits between heartbeat gen and pin.
// PARAMETERS
// CODE_W     4    width of err_code; max pulse count = 2**CODE_W-1
// GAP_TICKS  4    ticks of LED-off gap after each code burst; legal range 1..15
// PWM_W      8    width of brightness and PWM counter
// PORTS
// clk          in   1       system clock, single domain
// reset        in   1       synchronous, active-high reset
// hb_in        in   1       heartbeat level from heartbeat generator, same clk domain
// err_code     in   CODE_W  error code; 0 = no error
// err_valid    in   1       err_code qualifier; sampled only at sequence start
// brightness   in   PWM_W   LED duty; 0 = off, all-ones = fully on
// led_out      out  1       registered LED drive
// busy         out  1       high while a blink-code sequence is in progress
// BEHAVIOUR
// Reset: state=IDLE, led_out=0, busy=0, pwm_cnt=0, pulse/gap counters=0, code latch=0.
//   During reset, hb_q <= hb_in, so no spurious tick occurs on reset release.
// Tick: hb_q <= hb_in every cycle; tick = hb_in ^ hb_q. Both edges count.
// All FSM transitions occur only on clock edges where tick=1; otherwise hold state.
// start_ok = err_valid && (err_code != 0).
// FSM:
//   IDLE: led_raw=hb_q. On tick && start_ok: latch code into pulse_cnt -> ON.
//   ON:   led_raw=1. On tick: pulse_cnt-- -> OFF.
//   OFF:  led_raw=0. On tick: pulse_cnt==0 -> GAP (gap_cnt=GAP_TICKS-1);
//         otherwise -> ON.
//   GAP:  led_raw=0. On tick: gap_cnt!=0 -> gap_cnt--;
//         gap_cnt==0 && start_ok -> relatch code, go to ON;
//         gap_cnt==0 && !start_ok -> IDLE.
// err_code and err_valid changes mid-sequence are ignored. The current burst and its
//   gap always complete. A new value takes effect at the next start.
// busy = (state != IDLE), combinational from state register.
// PWM: pwm_cnt free-runs +1 per clk and wraps 2**PWM_W-1 -> 0.
//   pwm_on = (brightness == all-ones) || (pwm_cnt < brightness), unsigned compare.
// led_out <= led_raw && pwm_on. Latency: one cycle from state/hb_q to led_out.
//   In IDLE at full brightness, led_out = hb_in delayed by 2 clk.
// Reset asserted mid-sequence: state=IDLE and led_out=0 on the next edge. Any
//   partial burst is discarded.
// TESTING
// 1. Hold hb_in=1 through reset, then release with err_valid=0 -> no tick fires,
//    busy=0, led_out follows hb_in with 2-cycle delay at brightness=8'hFF.
// 2. brightness=8'hFF, err_code=3, err_valid=1, toggle hb_in every 20 clk -> from the
//    next tick: ON,OFF x3, then 4 GAP ticks, then repeat. Exactly 3 high pulses per
//    burst, each 20 clk wide.
// 3. Change err_code 3->5 during the 2nd ON -> burst completes with 3 pulses, and the
//    following burst has 5 pulses.
// 4. Drop err_valid mid-burst -> burst and gap complete, then IDLE, busy=0, and
//    led_out mirrors hb_in again.
// 5. brightness=8'h40 in ON state -> led_out high 64 of every 256 clk.
//    brightness=0 -> led_out never high.
// 6. Assert reset for 1 clk during GAP -> next cycle led_out=0, busy=0, and a fresh
//    start requires a tick with start_ok.

Source files
------------

// File: rtl/led_blink_coder.sv
// Purpose: turns heartbeat edges into a slow tick and drives the board LED, either mirroring the heartbeat or blinking an error code.
// Latency: led_out is registered one clk after state/hb_q, so it shows hb_in two clk late in IDLE; a new sequence starts only on a tick.
// Backpressure: none; free-running consumer with no flow control, and code/valid are sampled only when a sequence starts.
module led_blink_coder #(
    parameter int CODE_W    = 4,
    parameter int GAP_TICKS = 4,
    parameter int PWM_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hb_in,
    input  logic [CODE_W-1:0] err_code,
    input  logic              err_valid,
    input  logic [PWM_W-1:0]  brightness,
    output logic              led_out,
    output logic              busy
);

    // GAP_TICKS is at most 15, so a 4-bit gap counter always suffices.
    localparam int             GAP_W    = 4;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_hb_q;
    logic              w_tick;
    logic              w_start_ok;
    logic [CODE_W-1:0] r_pulse_cnt;
    logic [CODE_W-1:0] w_pulse_cnt_nxt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [GAP_W-1:0]  w_gap_cnt_nxt;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic              w_pwm_on;
    logic              w_led_raw;

    // Either heartbeat edge is one time-base tick.
    assign w_tick     = hb_in ^ r_hb_q;
    assign w_start_ok = err_valid && (err_code != '0);

    // All-ones brightness bypasses the compare so the LED is truly always on.
    assign w_pwm_on = (&brightness) || (r_pwm_cnt < brightness);

    assign busy = (r_state != ST_IDLE);

    // Heartbeat delay register.
    // It also loads during reset, so releasing reset never produces a false tick.
    always_ff @(posedge clk) begin
        r_hb_q <= hb_in;
    end

    // Free-running PWM phase counter that wraps naturally at 2**PWM_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Blink FSM next-state, counters and raw LED level; transitions happen only on ticks.
    always_comb begin
        w_state_nxt     = r_state;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_led_raw       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_led_raw = r_hb_q;
                if (w_tick && w_start_ok) begin
                    w_pulse_cnt_nxt = err_code;
                    w_state_nxt     = ST_ON;
                end
            end
            ST_ON: begin
                w_led_raw = 1'b1;
                if (w_tick) begin
                    w_pulse_cnt_nxt = r_pulse_cnt - 1'b1;
                    w_state_nxt     = ST_OFF;
                end
            end
            ST_OFF: begin
                if (w_tick) begin
                    if (r_pulse_cnt == '0) begin
                        w_gap_cnt_nxt = GAP_LOAD;
                        w_state_nxt   = ST_GAP;
                    end else begin
                        w_state_nxt   = ST_ON;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_gap_cnt != '0) begin
                        w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                    end else if (w_start_ok) begin
                        // Back-to-back bursts pick up whatever code is current now.
                        w_pulse_cnt_nxt = err_code;
                        w_state_nxt     = ST_ON;
                    end else begin
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered LED drive. Reset discards any partial burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pulse_cnt <= '0;
            r_gap_cnt   <= '0;
            led_out     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            led_out     <= w_led_raw && w_pwm_on;
        end
    end

endmodule

// File: tb/tb_led_blink_coder.sv
// Bench for led_blink_coder: LED segment widths go through a scoreboard queue, and state checks are made inline.
// Timing: inputs are driven 1 ns after posedge, and the monitor samples on negedge.
// Heartbeat toggles every 20 clk, so each LED level segment should last a whole number of 20-clk ticks.
module tb_led_blink_coder;

    logic       clk;
    logic       reset;
    logic       hb_in;
    logic [3:0] err_code;
    logic       err_valid;
    logic [7:0] brightness;
    logic       led_out;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    typedef struct packed {
        logic        lvl;
        logic [31:0] w;
    } seg_t;

    seg_t exp_q[$];

    led_blink_coder #(.CODE_W(4), .GAP_TICKS(4), .PWM_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .hb_in      (hb_in),
        .err_code   (err_code),
        .err_valid  (err_valid),
        .brightness (brightness),
        .led_out    (led_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push_seg(input logic lvl, input int w);
        seg_t s;
        s.lvl = lvl;
        s.w   = w;
        exp_q.push_back(s);
    endtask

    // Wait n clocks, then toggle the heartbeat just after the edge.
    task automatic hb_tick(input int n);
        repeat (n) @(posedge clk);
        #1 hb_in = ~hb_in;
    endtask

    // Count the cycles led_out is high over n consecutive negedges.
    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (led_out === 1'b1) c++;
        end
    endtask

    // Monitor: measures each completed LED level segment and compares it with the next expected entry.
    initial begin : monitor
        logic prev;
        int   cnt;
        bit   have;
        seg_t e;
        prev = 1'b0;
        cnt  = 0;
        have = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                have = 0;
                prev = led_out;
                cnt  = 0;
            end else if (led_out !== prev) begin
                if (have) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL seg_extra: got lvl=%0b w=%0d want none", prev, cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.lvl !== prev || e.w != cnt) begin
                            bad++;
                            $display("FAIL seg: got lvl=%0b w=%0d want lvl=%0b w=%0d", prev, cnt, e.lvl, e.w);
                        end
                    end
                end
                have = 1;
                prev = led_out;
                cnt  = 1;
            end else begin
                cnt++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        reset      = 1'b1;
        hb_in      = 1'b1;
        err_valid  = 1'b1;
        err_code   = 4'd3;
        brightness = 8'hFF;

        // Reset state, with the heartbeat held high throughout reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_led", led_out, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Releasing reset must not create a tick, even with a valid code pending.
        repeat (5) @(negedge clk);
        chk("no_spurious_busy", busy, 0);
        chk("idle_led_mirror_hi", led_out, 1);

        // Idle mirror: led_out follows hb_in two clk late.
        err_valid = 1'b0;
        @(posedge clk);
        #1 hb_in = 1'b0;
        @(negedge clk);
        chk("mirror_d0", led_out, 1);
        @(negedge clk);
        chk("mirror_d1", led_out, 1);
        @(negedge clk);
        chk("mirror_d2", led_out, 0);
        chk("mirror_busy", busy, 0);

        // Blink bursts: code 3, then 5 after a mid-burst change, then valid drops and the LED mirrors again.
        repeat (10) @(posedge clk);
        #1 mon_en = 1'b1;
        err_valid = 1'b1;
        err_code  = 4'd3;
        for (int k = 0; k < 3; k++) begin
            push_seg(1'b1, 20);
            if (k < 2) push_seg(1'b0, 20);
        end
        push_seg(1'b0, 100);
        for (int k = 0; k < 5; k++) begin
            push_seg(1'b1, 20);
            if (k < 4) push_seg(1'b0, 20);
        end
        push_seg(1'b0, 100);
        for (int k = 0; k < 6; k++) begin
            push_seg(1'b1, 20);
            push_seg(1'b0, 20);
        end

        for (int j = 0; j <= 36; j++) begin
            hb_tick((j == 0) ? 5 : 20);
            if (j == 2)  err_code = 4'd5;
            if (j == 6)  chk("busy_in_burst", busy, 1);
            if (j == 12) err_valid = 1'b0;
            if (j == 26) chk("busy_after_gap", busy, 0);
        end
        repeat (5) @(posedge clk);
        #1 mon_en = 1'b0;
        chk("seg_queue_empty", exp_q.size(), 0);

        // PWM duty while held in ON with no heartbeat edges.
        hb_tick(1);
        repeat (5) @(posedge clk);
        #1 brightness = 8'h40;
        err_valid = 1'b1;
        err_code  = 4'd1;
        hb_tick(1);
        repeat (5) @(posedge clk);
        chk("pwm_busy_on", busy, 1);
        count_high(256, c);
        chk("pwm_40", c, 64);
        brightness = 8'h00;
        repeat (3) @(posedge clk);
        count_high(256, c);
        chk("pwm_00", c, 0);
        brightness = 8'hFF;
        repeat (3) @(posedge clk);
        count_high(256, c);
        chk("pwm_ff", c, 256);

        // Reset pulse while in GAP.
        err_valid = 1'b0;
        hb_tick(1);
        hb_tick(20);
        repeat (5) @(posedge clk);
        #1;
        chk("gap_busy", busy, 1);
        chk("gap_led", led_out, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_led", led_out, 0);
        chk("midrst_busy", busy, 0);

        // After reset, a start needs both a tick and start_ok.
        hb_tick(1);
        repeat (5) @(posedge clk);
        #1;
        chk("tick_no_valid_busy", busy, 0);
        err_valid = 1'b1;
        err_code  = 4'd2;
        repeat (5) @(posedge clk);
        #1;
        chk("valid_no_tick_busy", busy, 0);
        hb_tick(1);
        repeat (3) @(posedge clk);
        #1;
        chk("restart_busy", busy, 1);
        chk("restart_led", led_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
